// File: rtl/fir_serial_param.sv
`default_nettype none
// ============================================================================
// fir_serial_param : reconfigurable single-MAC serial FIR with shift/saturate
// Revision 1.0
// ============================================================================
module fir_serial_param #(
  parameter int DW       = 8,
  parameter int CW       = 8,
  parameter int MAX_TAPS = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] data_in,
  input  logic          enable,
  input  logic          configuration,
  input  logic          config_data_enable,
  output logic [DW-1:0] data_out,
  output logic [1:0]    overflow_flag,
  output logic          done,
  output logic          busy
);

  localparam int TW = $clog2(MAX_TAPS);
  localparam int AW = DW + CW + TW;
  localparam int SW = $clog2(AW);
  localparam int PW = $clog2(MAX_TAPS + 3);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CONFIG = 2'd1;
  localparam logic [1:0] S_MAC    = 2'd2;
  localparam logic [1:0] S_OUT    = 2'd3;

  localparam logic [PW-1:0] PTR_END = PW'(MAX_TAPS + 2);
  localparam logic [PW-1:0] PTR_C0  = PW'(2);
  localparam logic signed [AW-1:0] RES_MAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] RES_MIN = ~RES_MAX;

  logic [1:0]           state;
  logic [PW-1:0]        ptr;
  logic [TW-1:0]        n_m1;
  logic [SW-1:0]        shift;
  logic [TW-1:0]        idx;
  logic signed [AW-1:0] acc;
  logic signed [CW-1:0] coef [MAX_TAPS];
  logic signed [DW-1:0] x    [MAX_TAPS];

  logic signed [DW+CW-1:0] prod;
  logic signed [AW-1:0]    acc_next;
  logic signed [AW-1:0]    res;
  logic [31:0]             din_ext;
  logic [TW-1:0]           cidx;
  logic [PW-1:0]           ptr_off;

  assign prod     = coef[idx] * x[idx];
  assign acc_next = acc + {{TW{prod[DW+CW-1]}}, prod};
  assign res      = acc >>> shift;
  assign din_ext  = {{(32-DW){1'b0}}, data_in};
  assign ptr_off  = ptr - PTR_C0;
  assign cidx     = ptr_off[TW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      ptr           <= '0;
      n_m1          <= '0;
      shift         <= '0;
      idx           <= '0;
      acc           <= '0;
      data_out      <= '0;
      overflow_flag <= 2'b00;
      done          <= 1'b0;
      busy          <= 1'b0;
      for (int k = 0; k < MAX_TAPS; k++) begin
        coef[k] <= '0;
        x[k]    <= '0;
      end
    end else begin
      done <= 1'b0;
      // busy lags the state by one edge so it spans the MAC and OUT cycles as seen outside
      busy <= (state == S_MAC) || (state == S_OUT);
      case (state)
        S_IDLE: begin
          if (configuration) begin
            state <= S_CONFIG;
            ptr   <= '0;
            for (int k = 0; k < MAX_TAPS; k++) begin
              coef[k] <= '0;
              x[k]    <= '0;
            end
          end else if (enable) begin
            for (int k = MAX_TAPS - 1; k > 0; k--) begin
              x[k] <= x[k-1];
            end
            x[0]  <= data_in;
            acc   <= '0;
            idx   <= '0;
            state <= S_MAC;
          end
        end
        S_CONFIG: begin
          if (config_data_enable) begin
            if (ptr == '0) begin
              n_m1 <= data_in[TW-1:0];
            end else if (ptr == PW'(1)) begin
              shift <= (din_ext > 32'(AW - 1)) ? SW'(AW - 1) : din_ext[SW-1:0];
            end else if (ptr != PTR_END) begin
              coef[cidx] <= data_in[CW-1:0];
            end
            if (ptr != PTR_END) begin
              ptr <= ptr + PW'(1);
            end
          end
          if (!configuration) begin
            state <= S_IDLE;
          end
        end
        S_MAC: begin
          acc <= acc_next;
          if (idx == n_m1) begin
            state <= S_OUT;
          end else begin
            idx <= idx + TW'(1);
          end
        end
        default: begin
          if (res > RES_MAX) begin
            data_out      <= {1'b0, {(DW-1){1'b1}}};
            overflow_flag <= 2'b01;
          end else if (res < RES_MIN) begin
            data_out      <= {1'b1, {(DW-1){1'b0}}};
            overflow_flag <= 2'b10;
          end else begin
            data_out      <= res[DW-1:0];
            overflow_flag <= 2'b00;
          end
          done  <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fir_serial_param.sv
`default_nettype none
// tb_fir_serial_param : directed table-driven checks of the serial FIR.
module tb_fir_serial_param;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data_in = '0;
  logic       enable = 1'b0;
  logic       configuration = 1'b0;
  logic       config_data_enable = 1'b0;
  logic [7:0] data_out;
  logic [1:0] overflow_flag;
  logic       done;
  logic       busy;

  int checks = 0;
  int errors = 0;
  logic [7:0] cfg_q[$];

  fir_serial_param dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .enable(enable),
    .configuration(configuration), .config_data_enable(config_data_enable),
    .data_out(data_out), .overflow_flag(overflow_flag), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cfg;
    logic [7:0] din;
    logic [7:0] exp_out;
    logic [1:0] exp_flag;
    int         lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_words();
    for (int i = 0; i < cfg_q.size(); i++) begin
      data_in = cfg_q[i];
      config_data_enable = 1'b1;
      tick();
    end
    config_data_enable = 1'b0;
  endtask

  task automatic do_config();
    configuration = 1'b1;
    tick();
    write_words();
    configuration = 1'b0;
    tick();
  endtask

  task automatic load_cfg(input int id);
    cfg_q.delete();
    case (id)
      0: cfg_q = '{8'd3, 8'd0, 8'd1, 8'd1, 8'd1, 8'd1};
      1, 2: cfg_q = '{8'd3, 8'd0, 8'h7F, 8'h7F, 8'h7F, 8'h7F};
      default: cfg_q = '{8'd0, 8'd4, 8'h10};
    endcase
    do_config();
  endtask

  // Enable one sample and wait (bounded) for done; checks latency, output, flag, busy.
  task automatic run_sample(input string name, input logic [7:0] din, input logic [7:0] eo,
                            input logic [1:0] ef, input int lat);
    int k;
    logic got;
    data_in = din;
    enable = 1'b1;
    tick();
    enable = 1'b0;
    k = 0;
    got = 1'b0;
    while (k < 40 && !got) begin
      tick();
      k++;
      if (k == 1) chk({name, "_busy_rise"}, 32'(busy), 32'd1);
      if (done) got = 1'b1;
    end
    chk({name, "_latency"}, 32'(k), 32'(lat));
    chk({name, "_out"}, 32'(data_out), 32'(eo));
    chk({name, "_flag"}, 32'(overflow_flag), 32'(ef));
    tick();
    chk({name, "_busy_fall"}, 32'(busy), 32'd0);
    chk({name, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  vec_t tbl[11];

  initial begin
    int k;
    logic seen;
    tbl[0]  = '{0, 8'd10,  8'd10,  2'b00, 5};
    tbl[1]  = '{0, 8'd20,  8'd30,  2'b00, 5};
    tbl[2]  = '{0, 8'd30,  8'd60,  2'b00, 5};
    tbl[3]  = '{0, 8'd40,  8'd100, 2'b00, 5};
    tbl[4]  = '{1, 8'h7F,  8'h7F,  2'b01, 5};
    tbl[5]  = '{2, 8'h80,  8'h80,  2'b10, 5};
    tbl[6]  = '{3, 8'd5,   8'd5,   2'b00, 2};
    tbl[7]  = '{3, 8'hFB,  8'hFB,  2'b00, 2};
    tbl[8]  = '{3, 8'hFF,  8'hFF,  2'b00, 2};
    tbl[9]  = '{3, 8'd7,   8'd7,   2'b00, 2};
    tbl[10] = '{3, 8'hF8,  8'hF8,  2'b00, 2};

    // Reset state
    #12;
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_flag", 32'(overflow_flag), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Reset-state filter: N=1, c0=0 gives zero
    run_sample("rst_default", 8'h33, 8'h00, 2'b00, 2);

    for (int i = 0; i < 11; i++) begin
      if (i == 0 || tbl[i].cfg != tbl[i-1].cfg) load_cfg(tbl[i].cfg);
      run_sample($sformatf("vec%0d", i), tbl[i].din, tbl[i].exp_out, tbl[i].exp_flag, tbl[i].lat);
    end

    // Max depth with an enable dropped during MAC
    cfg_q.delete();
    cfg_q.push_back(8'h0F);
    cfg_q.push_back(8'h00);
    for (int i = 0; i < 16; i++) cfg_q.push_back(8'h01);
    do_config();
    run_sample("max_first", 8'd1, 8'd1, 2'b00, 17);
    data_in = 8'd2;
    enable = 1'b1;
    tick();
    enable = 1'b0;
    tick();
    data_in = 8'd100;
    enable = 1'b1;
    tick();
    enable = 1'b0;
    data_in = 8'd0;
    k = 2;
    seen = 1'b0;
    while (k < 40 && !seen) begin
      tick();
      k++;
      if (done) seen = 1'b1;
    end
    chk("max_latency", 32'(k), 32'd17);
    chk("max_out", 32'(data_out), 32'd3);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done) seen = 1'b1;
    end
    chk("max_no_extra_done", 32'(seen), 32'd0);
    run_sample("max_no_extra_shift", 8'd0, 8'd3, 2'b00, 17);

    // Reset during the second MAC cycle
    load_cfg(0);
    run_sample("pre_rst", 8'd50, 8'd50, 2'b00, 5);
    data_in = 8'd10;
    enable = 1'b1;
    tick();
    enable = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_data_out", 32'(data_out), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done) seen = 1'b1;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done) seen = 1'b1;
    end
    chk("midrst_no_done", 32'(seen), 32'd0);
    run_sample("post_rst", 8'h55, 8'h00, 2'b00, 2);

    // Configuration takes priority over a simultaneous enable
    cfg_q = '{8'd0, 8'd0, 8'd3};
    do_config();
    run_sample("prio_pre", 8'd7, 8'd21, 2'b00, 2);
    configuration = 1'b1;
    enable = 1'b1;
    data_in = 8'd9;
    tick();
    enable = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done || busy) seen = 1'b1;
    end
    chk("prio_no_mac", 32'(seen), 32'd0);
    cfg_q = '{8'd1, 8'd0, 8'd2, 8'd5};
    write_words();
    configuration = 1'b0;
    tick();
    run_sample("prio_cleared_line", 8'd4, 8'd8, 2'b00, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire
